seq_divider: RTL and testbench

- Parametrised, multi-cycle restoring divider for the execute stage.
- Covers the full RV64M divide/remainder set: DIV, DIVU, REM, REMU and the W forms DIVW, DIVUW, REMW, REMUW.
- Does its own sign handling, special-case resolution and word sign-extension, so the ALU only muxes `result`.
- valid/ready handshakes on both sides; supports pipeline flush and output back-pressure.

---
 rtl/seq_divider.sv | 210 +++++++++++++++++++++
 tb/tb_seq_divider.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider for the RV64M DIV/REM family (W forms included)
// Optional early-out of trivial divides: SEQ_DIVIDER_EARLY_OUT_EN
module seq_divider #(
  parameter int XLEN = 64,
  parameter int WLEN = XLEN / 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   N_FULL = CW'(XLEN);
  localparam logic [CW-1:0]   N_WORD = CW'(WLEN);
  localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W  = {{(XLEN-WLEN){1'b0}}, 1'b1, {(WLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] mag_b_q, mag_b_d;
  logic [XLEN-1:0] a_q, a_d;
  logic            rem_op_q, rem_op_d;
  logic            word_q, word_d;
  logic            a_neg_q, a_neg_d;
  logic            b_neg_q, b_neg_d;
  logic            b_zero_q, b_zero_d;
  logic            ovf_q, ovf_d;
  logic            settle_q, settle_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            out_valid_q, out_valid_d;

  // Operand conditioning at the op width; word operands are extended first.
  logic            op_uns, op_word;
  logic [XLEN-1:0] op_a, op_b, mag_a, mag_b;
  logic            a_neg, b_neg, b_zero, ovf, early;

  always_comb begin
    op_uns  = op[0];
    op_word = op[2];
    if (op_word) begin
      op_a = op_uns ? {{(XLEN-WLEN){1'b0}}, a[WLEN-1:0]} : {{(XLEN-WLEN){a[WLEN-1]}}, a[WLEN-1:0]};
      op_b = op_uns ? {{(XLEN-WLEN){1'b0}}, b[WLEN-1:0]} : {{(XLEN-WLEN){b[WLEN-1]}}, b[WLEN-1:0]};
    end else begin
      op_a = a;
      op_b = b;
    end
    a_neg  = ~op_uns & op_a[XLEN-1];
    b_neg  = ~op_uns & op_b[XLEN-1];
    mag_a  = a_neg ? -op_a : op_a;
    mag_b  = b_neg ? -op_b : op_b;
    b_zero = (op_b == '0);
    ovf    = a_neg & (mag_a == (op_word ? MIN_W : MIN_X)) & (op_b == '1);
    early  = b_zero | ovf | (mag_a < mag_b);
  end

  logic [XLEN:0]   rem_shift, diff;
  logic [XLEN-1:0] quo_mag, q_val, r_val, res_full, res_fix;

  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, mag_b_q};

    quo_mag = word_q ? {{(XLEN-WLEN){1'b0}}, quo_q[WLEN-1:0]} : quo_q;
    q_val   = (a_neg_q ^ b_neg_q) ? -quo_mag : quo_mag;
    r_val   = a_neg_q ? -rem_q : rem_q;
    if (b_zero_q) begin
      q_val = '1;
      r_val = a_q;
    end else if (ovf_q) begin
      q_val = a_q;
      r_val = '0;
    end
    res_full = rem_op_q ? r_val : q_val;
    res_fix  = word_q ? {{(XLEN-WLEN){res_full[WLEN-1]}}, res_full[WLEN-1:0]} : res_full;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    mag_b_d     = mag_b_q;
    a_d         = a_q;
    rem_op_d    = rem_op_q;
    word_d      = word_q;
    a_neg_d     = a_neg_q;
    b_neg_d     = b_neg_q;
    b_zero_d    = b_zero_q;
    ovf_d       = ovf_q;
    settle_d    = settle_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      settle_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            rem_op_d = op[1];
            word_d   = op_word;
            a_neg_d  = a_neg;
            b_neg_d  = b_neg;
            b_zero_d = b_zero;
            ovf_d    = ovf;
            a_d      = op_a;
            mag_b_d  = mag_b;
            rem_d    = '0;
            quo_d    = op_word ? (mag_a << WLEN) : mag_a;
            cnt_d    = op_word ? N_WORD : N_FULL;
            state_d  = S_CALC;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
            // Trivial divides park in FIX for one extra cycle, giving a fixed 2-cycle latency.
            if (early) begin
              rem_d    = mag_a;
              quo_d    = '0;
              settle_d = 1'b1;
              state_d  = S_FIX;
            end
`endif
          end
        end
        S_CALC: begin
          if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          if (settle_q) begin
            settle_d = 1'b0;
          end else begin
            result_d    = res_fix;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      mag_b_q     <= '0;
      a_q         <= '0;
      rem_op_q    <= 1'b0;
      word_q      <= 1'b0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      b_zero_q    <= 1'b0;
      ovf_q       <= 1'b0;
      settle_q    <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      mag_b_q     <= mag_b_d;
      a_q         <= a_d;
      rem_op_q    <= rem_op_d;
      word_q      <= word_d;
      a_neg_q     <= a_neg_d;
      b_neg_q     <= b_neg_d;
      b_zero_q    <= b_zero_d;
      ovf_q       <= ovf_d;
      settle_q    <= settle_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed scoreboard bench for seq_divider
module tb_seq_divider;
  localparam int XLEN = 64;
  localparam logic [2:0] DIV = 3'b000, DIVU = 3'b001, REM = 3'b010, REMU = 3'b011;
  localparam logic [2:0] DIVW = 3'b100, DIVUW = 3'b101, REMW = 3'b110, REMUW = 3'b111;

  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] op = '0;
  logic [XLEN-1:0] a = '0, b = '0;
  logic in_ready, out_valid, busy;
  logic [XLEN-1:0] result;

  seq_divider #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input logic [2:0] o, input bit early);
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    if (early) return 2;
`endif
    return o[2] ? 33 : 65;
  endfunction

  task automatic start_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] exp, input bit early);
    exp_t e;
    e.res = exp;
    e.lat = lat_of(o, early);
    sb.push_back(e);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  task automatic wait_result(input string tag);
    int lat = 0;
    exp_t e;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, result);
    end else begin
      e = sb.pop_front();
      check($sformatf("%s_lat", tag), 64'(lat), 64'(e.lat));
      check(tag, result, e.res);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hs_out_valid", {63'b0, out_valid}, 64'd0);
    check("hs_in_ready", {63'b0, in_ready}, 64'd1);
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] exp, input bit early);
    start_op(o, x, y, exp, early);
    wait_result(tag);
    handshake();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] held;
    bit seen;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_result", result, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_op("div_neg7_2", DIV, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 1'b0);
    do_op("rem_neg7_2", REM, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    do_op("divu_by0", DIVU, 64'd100, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    do_op("remu_by0", REMU, 64'd100, 64'd0, 64'd100, 1'b1);
    do_op("remw_by0", REMW, 64'h0000000080000005, 64'd0, 64'hFFFFFFFF80000005, 1'b1);
    do_op("div_ovf", DIV, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1'b1);
    do_op("rem_ovf", REM, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
    do_op("divw_ovf", DIVW, 64'h0000000080000000, 64'h00000000FFFFFFFF, 64'hFFFFFFFF80000000, 1'b1);
    do_op("divuw_max_2", DIVUW, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'h000000007FFFFFFF, 1'b0);
    do_op("divw_neg8_3", DIVW, 64'h12345678FFFFFFF8, 64'd3, 64'hFFFFFFFFFFFFFFFE, 1'b0);
    do_op("remw_neg5_3", REMW, 64'h00000000FFFFFFFB, 64'd3, 64'hFFFFFFFFFFFFFFFE, 1'b0);
    do_op("div_small", DIV, 64'd5, 64'hFFFFFFFFFFFFFFF9, 64'd0, 1'b1);
    do_op("rem_small", REM, 64'd5, 64'hFFFFFFFFFFFFFFF9, 64'd5, 1'b1);
    do_op("remuw", REMUW, 64'hAAAAAAAAFFFFFFF0, 64'h0000000000000100, 64'h00000000000000F0, 1'b0);
    do_op("divuw_sext", DIVUW, 64'h0000000080000000, 64'd1, 64'hFFFFFFFF80000000, 1'b0);
    do_op("remu_max_10", REMU, 64'hFFFFFFFFFFFFFFFF, 64'd10, 64'd5, 1'b0);

    // Back-pressure: result held while the consumer stalls.
    start_op(DIVU, 64'hFFFFFFFFFFFFFFFF, 64'd10, 64'h1999999999999999, 1'b0);
    wait_result("bp_divu");
    held = result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_result", result, 64'h1999999999999999);
      check("bp_out_valid", {63'b0, out_valid}, 64'd1);
      check("bp_in_ready", {63'b0, in_ready}, 64'd0);
      check("bp_busy", {63'b0, busy}, 64'd1);
    end
    handshake();
    do_op("after_bp", DIV, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 1'b0);

    // in_valid while busy is ignored.
    start_op(DIVU, 64'd100, 64'd7, 64'd14, 1'b0);
    op = DIVU; a = 64'd1000; b = 64'd1; in_valid = 1'b1;
    wait_result("busy_ignore");
    in_valid = 1'b0;
    handshake();

    // Flush during CALC iteration 10.
    op = DIVU; a = 64'hFFFFFFFFFFFFFFFF; b = 64'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_in_ready", {63'b0, in_ready}, 64'd1);
    check("flush_busy", {63'b0, busy}, 64'd0);
    check("flush_out_valid", {63'b0, out_valid}, 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", {63'b0, seen}, 64'd0);
    do_op("post_flush", DIVU, 64'd10, 64'd3, 64'd3, 1'b0);

    // Flush together with in_valid: no accept.
    op = DIVU; a = 64'd50; b = 64'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush_acc_busy", {63'b0, busy}, 64'd0);
    check("flush_acc_in_ready", {63'b0, in_ready}, 64'd1);

    // Async reset mid-CALC.
    op = DIVU; a = 64'd1000; b = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_mid_busy", {63'b0, busy}, 64'd0);
    check("rst_mid_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_mid_result", result, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst_no_stale_valid", {63'b0, seen}, 64'd0);
    do_op("post_reset", DIVU, 64'd10, 64'd3, 64'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
